// File: rtl/breath_sched_pkg.sv
// Shared types and constants for the breathing-LED profile scheduler.
package breath_sched_pkg;
    localparam int STEP_W = 10;
    localparam logic [STEP_W-1:0] DEFAULT_STEP = 10'd100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        FIN  = 2'd3
    } sched_state_t;
endpackage

// File: rtl/breath_led_sched_if.sv
// Host/PWM-facing signal bundle of the scheduler; master = host side, slave = scheduler.
interface breath_led_sched_if #(
    parameter int NUM_PROFILES = 4,
    parameter int DWELL_W      = 16
);
    import breath_sched_pkg::*;
    localparam int AW = $clog2(NUM_PROFILES);

    logic               cfg_we;
    logic [AW-1:0]      cfg_addr;
    logic [STEP_W-1:0]  cfg_step;
    logic [DWELL_W-1:0] cfg_dwell;
    logic               start;
    logic               stop;
    logic               loop_en;
    logic               sw_ctrl;
    logic               set_en;
    logic [STEP_W-1:0]  set_freq_step;
    logic               busy;
    logic [AW-1:0]      cur_idx;
    logic               done;

    modport master (
        output cfg_we, cfg_addr, cfg_step, cfg_dwell, start, stop, loop_en,
        input  sw_ctrl, set_en, set_freq_step, busy, cur_idx, done
    );
    modport slave (
        input  cfg_we, cfg_addr, cfg_step, cfg_dwell, start, stop, loop_en,
        output sw_ctrl, set_en, set_freq_step, busy, cur_idx, done
    );
endinterface

// File: rtl/breath_profile_regs.sv
// Profile table: one synchronous write port, combinational reads for the current
// entry, the following entry (wrapping), and a direct tap on entry 0's dwell.
module breath_profile_regs
    import breath_sched_pkg::*;
#(
    parameter int NUM_PROFILES = 4,
    parameter int DWELL_W      = 16
) (
    input  logic                            sys_clk,
    input  logic                            sys_rst,
    input  logic                            we,
    input  logic [$clog2(NUM_PROFILES)-1:0] wr_addr,
    input  logic [STEP_W-1:0]               wr_step,
    input  logic [DWELL_W-1:0]              wr_dwell,
    input  logic [$clog2(NUM_PROFILES)-1:0] rd_a_addr,
    output logic [STEP_W-1:0]               rd_a_step,
    output logic [DWELL_W-1:0]              rd_a_dwell,
    input  logic [$clog2(NUM_PROFILES)-1:0] rd_b_addr,
    output logic [DWELL_W-1:0]              rd_b_dwell,
    output logic [DWELL_W-1:0]              head_dwell
);
    localparam int AW = $clog2(NUM_PROFILES);

    logic [NUM_PROFILES-1:0][STEP_W-1:0]  step_q;
    logic [NUM_PROFILES-1:0][DWELL_W-1:0] dwell_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < NUM_PROFILES; i++) begin
                step_q[i]  <= DEFAULT_STEP;
                dwell_q[i] <= '0;
            end
        end else if (we) begin
            step_q[wr_addr]  <= wr_step;
            dwell_q[wr_addr] <= wr_dwell;
        end
    end

    assign rd_a_step  = step_q[rd_a_addr];
    assign rd_a_dwell = dwell_q[rd_a_addr];
    assign rd_b_dwell = dwell_q[rd_b_addr];
    assign head_dwell = dwell_q[AW'(0)];
endmodule

// File: rtl/breath_led_sched.sv
// Plays the profile table into the PWM block: LOAD strobes the step, RUN dwells
// dwell*TICK_CYCLES clocks, FIN pulses done. Outputs decode from state only.
module breath_led_sched
    import breath_sched_pkg::*;
#(
    parameter int NUM_PROFILES = 4,
    parameter int TICK_CYCLES  = 50_000,
    parameter int DWELL_W      = 16
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    breath_led_sched_if.slave  bus
);
    localparam int AW = $clog2(NUM_PROFILES);
    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [AW-1:0] LAST_IDX  = AW'(NUM_PROFILES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    sched_state_t       state_q, state_d;
    logic [AW-1:0]      idx_q, idx_d;
    logic [TW-1:0]      tick_q;
    logic [DWELL_W-1:0] dwell_cnt_q, cur_dwell_q;
    logic [STEP_W-1:0]  rd_step;
    logic [DWELL_W-1:0] rd_dwell, nxt_dwell, head_dwell;
    logic               tick_wrap, entry_done;
    logic               sw_ctrl, set_en, busy, done;
    logic [STEP_W-1:0]  set_freq_step;

    breath_profile_regs #(
        .NUM_PROFILES (NUM_PROFILES),
        .DWELL_W      (DWELL_W)
    ) u_regs (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .we         (bus.cfg_we),
        .wr_addr    (bus.cfg_addr),
        .wr_step    (bus.cfg_step),
        .wr_dwell   (bus.cfg_dwell),
        .rd_a_addr  (idx_q),
        .rd_a_step  (rd_step),
        .rd_a_dwell (rd_dwell),
        .rd_b_addr  (idx_q + AW'(1)),
        .rd_b_dwell (nxt_dwell),
        .head_dwell (head_dwell)
    );

    // Dwell is latched at LOAD so a table write during RUN cannot stretch the live entry.
    assign tick_wrap  = (tick_q == TICK_LAST);
    assign entry_done = (state_q == RUN) && tick_wrap && (dwell_cnt_q == cur_dwell_q - DWELL_W'(1));

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: if (bus.start && !bus.stop) begin
                idx_d   = '0;
                state_d = (head_dwell != '0) ? LOAD : FIN;
            end
            LOAD: state_d = bus.stop ? FIN : RUN;
            RUN: begin
                if (bus.stop) begin
                    state_d = FIN;
                end else if (entry_done) begin
                    if (idx_q != LAST_IDX && nxt_dwell != '0) begin
                        idx_d   = idx_q + AW'(1);
                        state_d = LOAD;
                    end else if (bus.loop_en && head_dwell != '0) begin
                        idx_d   = '0;
                        state_d = LOAD;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // dwell_cnt tops out at cur_dwell, so a full-scale dwell never wraps.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tick_q      <= '0;
            dwell_cnt_q <= '0;
            cur_dwell_q <= '0;
        end else if (state_q == LOAD) begin
            tick_q      <= '0;
            dwell_cnt_q <= '0;
            cur_dwell_q <= rd_dwell;
        end else if (state_q == RUN) begin
            tick_q <= tick_wrap ? '0 : tick_q + TW'(1);
            if (tick_wrap)
                dwell_cnt_q <= dwell_cnt_q + DWELL_W'(1);
        end
    end

    always_comb begin
        sw_ctrl       = 1'b0;
        busy          = 1'b0;
        set_en        = 1'b0;
        set_freq_step = '0;
        done          = 1'b0;
        case (state_q)
            LOAD: begin
                sw_ctrl       = 1'b1;
                busy          = 1'b1;
                set_en        = 1'b1;
                set_freq_step = rd_step;
            end
            RUN: begin
                sw_ctrl = 1'b1;
                busy    = 1'b1;
            end
            FIN:     done = 1'b1;
            default: ;
        endcase
    end

    assign bus.sw_ctrl       = sw_ctrl;
    assign bus.busy          = busy;
    assign bus.set_en        = set_en;
    assign bus.set_freq_step = set_freq_step;
    assign bus.done          = done;
    assign bus.cur_idx       = idx_q;
endmodule
